one_addr_detector: RTL and testbench

Captures an N-bit word on a single-cycle valid pulse. Emits the bit index of every set bit, one index per clock, in ascending order, each with vld_o high. Used as a bit-mask to index serializer, for example to turn a request or hit vector into a stream of addresses. One request is processed at a time; new requests are ignored while a sequence is in progress.

---
 rtl/one_addr_pkg.sv | 15 +
 rtl/one_addr_prio_enc.sv | 36 +++
 rtl/one_addr_detector.sv | 76 +++++++
 tb/tb_one_addr_detector.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/one_addr_pkg.sv
// one_addr_pkg
// Shared constants and helpers for the bit-mask to index serializer.
//   DEFAULT_N  : default data word width
//   addr_width : index width needed to address every bit of an N-bit word
package one_addr_pkg;

  localparam int DEFAULT_N = 5;

  // N is always >= 2 in legal builds; the guard keeps the width non-zero
  // if someone elaborates with N = 1 by mistake.
  function automatic int addr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/one_addr_prio_enc.sv
// one_addr_prio_enc
// Combinational N-bit priority encoder.
// Default build selects the lowest set bit; with ONE_ADDR_MSB_FIRST_EN
// defined it selects the highest set bit instead.
// Ports:
//   req [N-1:0]     : request vector
//   idx [WIDTH-1:0] : index of the selected bit (0 when none set)
//   any             : at least one bit of req is set
module one_addr_prio_enc
  import one_addr_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0]              req,
  output logic [addr_width(N)-1:0]  idx,
  output logic                      any
);

  localparam int WIDTH = addr_width(N);

  // The last matching iteration wins, so the scan direction sets priority.
  always_comb begin
    idx = '0;
    any = |req;
`ifdef ONE_ADDR_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = WIDTH'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = WIDTH'(i);
    end
`endif
  end

endmodule

// File: rtl/one_addr_detector.sv
// one_addr_detector
// Captures an N-bit word on a vld_i pulse and emits the index of every set
// bit, one per clock, with vld_o high. Ascending order by default; descending
// when ONE_ADDR_MSB_FIRST_EN is defined. Requests arriving while busy are
// dropped without sampling data.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous reset, active high
//   data  : word to scan, sampled only when a request is accepted
//   vld_i : request strobe
//   addr  : index of the current set bit (0 when vld_o is low), registered
//   vld_o : addr valid, registered
//   busy  : a sequence is pending or still being emitted
module one_addr_detector
  import one_addr_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              data,
  input  logic                      vld_i,
  output logic [addr_width(N)-1:0]  addr,
  output logic                      vld_o,
  output logic                      busy
);

  localparam int WIDTH = addr_width(N);

  logic [N-1:0]     pending;
  logic [N-1:0]     pending_nxt;
  logic [N-1:0]     clr_mask;
  logic [WIDTH-1:0] sel_idx;
  logic             sel_any;

  one_addr_prio_enc #(.N(N)) u_prio_enc (
    .req (pending),
    .idx (sel_idx),
    .any (sel_any)
  );

  // busy covers the bits still waiting plus the cycle carrying the last
  // address, so it drops exactly when vld_o falls.
  assign busy = (|pending) | vld_o;

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N; i++) begin
      clr_mask[i] = (WIDTH'(i) == sel_idx);
    end
  end

  // A request can only be accepted when nothing is pending, so the accept
  // and the clear paths never compete.
  always_comb begin
    pending_nxt = pending;
    if (sel_any) begin
      pending_nxt = pending & ~clr_mask;
    end else if (vld_i && !busy) begin
      pending_nxt = data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      addr    <= '0;
      vld_o   <= 1'b0;
    end else begin
      pending <= pending_nxt;
      vld_o   <= sel_any;
      addr    <= sel_any ? sel_idx : '0;
    end
  end

endmodule

// File: tb/tb_one_addr_detector.sv
module tb_one_addr_detector;

  localparam int N     = 5;
  localparam int WIDTH = $clog2(N);

  logic             clk   = 1'b0;
  logic             rst   = 1'b0;
  logic             vld_i = 1'b0;
  logic [N-1:0]     data  = '0;
  logic [WIDTH-1:0] addr;
  logic             vld_o;
  logic             busy;

  always #5 clk = ~clk;

  one_addr_detector #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .vld_i (vld_i),
    .addr  (addr),
    .vld_o (vld_o),
    .busy  (busy)
  );

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Cycle c is the state right after rising edge number c.
  int edge_n    = 0;
  int n_chk     = 0;
  int n_fail    = 0;
  int next_free = 0;
  int busy_lo   = 1;
  int busy_hi   = 0;
  int start_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: effect of the inputs presented at rising edge e.
  task automatic model(input int e, input logic r, input logic v, input logic [N-1:0] d);
    int k;
    if (r) begin
      exp_q.delete();
      busy_lo   = 1;
      busy_hi   = 0;
      next_free = e + 1;
      if (start_cyc < 0) start_cyc = e;
    end else if (v && start_cyc >= 0 && e >= next_free) begin
      k = 0;
`ifdef ONE_ADDR_MSB_FIRST_EN
      for (int i = N - 1; i >= 0; i--) begin
`else
      for (int i = 0; i < N; i++) begin
`endif
        if (d[i]) begin
          exp_q.push_back('{idx: i, cyc: e + 1 + k});
          k++;
        end
      end
      if (k > 0) begin
        busy_lo   = e;
        busy_hi   = e + k;
        next_free = e + k + 2;
      end else begin
        next_free = e + 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [N-1:0] d);
    @(negedge clk);
    rst   = r;
    vld_i = v;
    data  = d;
    model(edge_n + 1, r, v, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  task automatic req(input logic [N-1:0] d);
    step(1'b0, 1'b1, d);
  endtask

  task automatic wait_free();
    while (edge_n + 1 < next_free) idle(1);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    edge_n++;
    #1;
    if (start_cyc >= 0 && edge_n >= start_cyc) begin
      check("busy", int'(busy), int'(edge_n >= busy_lo && edge_n <= busy_hi));
      if (vld_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_vld", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("addr_cycle", edge_n, mon_e.cyc);
          check("addr", int'(addr), mon_e.idx);
        end
      end else begin
        check("addr_idle", int'(addr), 0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
          mon_e = exp_q.pop_front();
          check("missing_vld", 0, 1);
        end
      end
    end
  end

  initial begin
    int hold;
    int k;
    logic v;
    logic r;

    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    idle(2);

    // Abort a full-word sequence with a two-cycle reset.
    req(5'b11111);
    idle(2);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    idle(8);

    req(5'b00001);  wait_free();
    req(5'b10110);  wait_free();
    req(5'b11111);  wait_free();
    req(5'b00000);  idle(3);

    // Second request one cycle later must be dropped.
    req(5'b00011);
    req(5'b10000);
    wait_free();
    idle(2);

    // Every non-zero word, each issued at the earliest accept slot.
    for (int i = 1; i < (1 << N); i++) begin
      req(N'(i));
      wait_free();
    end
    idle(2);

    // Random traffic, including held vld_i and occasional resets.
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 149) == 0);
      if (hold == 0 && $urandom_range(0, 19) == 0) hold = $urandom_range(2, 12);
      v = (hold > 0) || ($urandom_range(0, 2) == 0);
      if (hold > 0) hold--;
      step(r, v, N'($urandom));
    end

    k = 0;
    while (exp_q.size() > 0 && k < 64) begin
      idle(1);
      k++;
    end
    idle(2);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
